// File: rtl/d16_wb_uart.sv
// d16_wb_uart: Wishbone-mapped 8N1 UART for the d16 CPU bus.
// Ports: i_clk, i_reset (async, active high); bus i_wb_addr/i_wb_cyc/
//   i_wb_we/i_wb_dat in, o_wb_dat out (combinational, no ack);
//   serial i_rx (asynchronous) and o_tx (idle high); o_int (3-bit vector).
// Registers (word offset): 0 DATA, 1 STATUS, 2 DIVISOR, 3 IRQEN.
module d16_wb_uart #(
    parameter logic [15:0] BASE_ADDR   = 16'hFFF0,
    parameter logic [15:0] DEFAULT_DIV = 16'd433,
    parameter logic [2:0]  IRQ_NUM     = 3'd1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_wb_addr,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [15:0] i_wb_dat,
    output logic [15:0] o_wb_dat,
    input  logic        i_rx,
    output logic        o_tx,
    output logic [2:0]  o_int
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_t;

    logic        w_sel, w_wr, w_rd;
    logic [1:0]  w_reg;
    logic        w_wr_data, w_rd_data, w_wr_stat;
    logic [15:0] w_half;
    logic        w_rx;

    logic [15:0] r_div;
    logic [1:0]  r_irqen;

    uart_state_t r_tx_state;
    logic [15:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_sh, r_tx_hold;
    logic        r_tx_ready, r_tx_busy, r_tx;

    logic        r_rx_s1, r_rx_s2;
    uart_state_t r_rx_state;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_sh, r_rx_byte;
    logic        r_rx_valid, r_rx_ovr, r_rx_ferr;
    logic [2:0]  r_int;

    assign w_sel     = i_wb_cyc && (i_wb_addr[15:2] == BASE_ADDR[15:2]);
    assign w_reg     = i_wb_addr[1:0];
    assign w_wr      = w_sel && i_wb_we;
    assign w_rd      = w_sel && !i_wb_we;
    assign w_wr_data = w_wr && (w_reg == 2'd0);
    assign w_wr_stat = w_wr && (w_reg == 2'd1);
    assign w_rd_data = w_rd && (w_reg == 2'd0);
    assign w_rx      = r_rx_s2;
    // Countdown preload so the start bit is sampled (DIV+1)/2 clocks in.
    assign w_half = ({1'b0, r_div[15:1]} + {15'd0, r_div[0]}) - 16'd1;

    assign o_tx  = r_tx;
    assign o_int = r_int;

    always_comb begin
        o_wb_dat = 16'd0;
        if (w_rd) begin
            unique case (w_reg)
                2'd0: o_wb_dat = {8'd0, r_rx_byte};
                2'd1: o_wb_dat = {11'd0, r_rx_ferr, r_tx_busy, r_rx_ovr,
                                  r_tx_ready, r_rx_valid};
                2'd2: o_wb_dat = r_div;
                2'd3: o_wb_dat = {14'd0, r_irqen};
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div   <= DEFAULT_DIV;
            r_irqen <= 2'b00;
        end else if (w_wr) begin
            if (w_reg == 2'd2)
                r_div <= (i_wb_dat < 16'd3) ? 16'd3 : i_wb_dat;
            if (w_reg == 2'd3)
                r_irqen <= i_wb_dat[1:0];
        end
    end

    // Transmitter: holding register plus shifter; r_tx_ready means the
    // holding register is empty.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 3'd0;
            r_tx_sh    <= 8'd0;
            r_tx_hold  <= 8'd0;
            r_tx_ready <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            if (w_wr_data && r_tx_ready) begin
                r_tx_hold  <= i_wb_dat[7:0];
                r_tx_ready <= 1'b0;
            end
            if (r_tx_state == S_IDLE) begin
                if (!r_tx_ready) begin
                    r_tx_sh    <= r_tx_hold;
                    r_tx_ready <= 1'b1;
                    r_tx_busy  <= 1'b1;
                    r_tx       <= 1'b0;
                    r_tx_cnt   <= r_div;
                    r_tx_state <= S_START;
                end
            end else if (r_tx_cnt != 16'd0) begin
                r_tx_cnt <= r_tx_cnt - 16'd1;
            end else begin
                // Bit boundary: reload from the live divisor.
                r_tx_cnt <= r_div;
                unique case (r_tx_state)
                    S_START: begin
                        r_tx       <= r_tx_sh[0];
                        r_tx_sh    <= {1'b0, r_tx_sh[7:1]};
                        r_tx_bit   <= 3'd0;
                        r_tx_state <= S_DATA;
                    end
                    S_DATA: begin
                        if (r_tx_bit == 3'd7) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= S_STOP;
                        end else begin
                            r_tx     <= r_tx_sh[0];
                            r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
                            r_tx_bit <= r_tx_bit + 3'd1;
                        end
                    end
                    S_STOP: begin
                        if (!r_tx_ready) begin
                            // Back-to-back frame, no idle gap.
                            r_tx_sh    <= r_tx_hold;
                            r_tx_ready <= 1'b1;
                            r_tx       <= 1'b0;
                            r_tx_state <= S_START;
                        end else begin
                            r_tx_busy  <= 1'b0;
                            r_tx_state <= S_IDLE;
                        end
                    end
                    default: r_tx_state <= S_IDLE;
                endcase
            end
        end
    end

    // Receiver. Flag sets are written after clears so a set wins.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_bit   <= 3'd0;
            r_rx_sh    <= 8'd0;
            r_rx_byte  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_s1 <= i_rx;
            r_rx_s2 <= r_rx_s1;
            if (w_rd_data)
                r_rx_valid <= 1'b0;
            if (w_wr_stat && i_wb_dat[2])
                r_rx_ovr <= 1'b0;
            if (w_wr_stat && i_wb_dat[4])
                r_rx_ferr <= 1'b0;
            if (r_rx_state == S_IDLE) begin
                if (!w_rx) begin
                    r_rx_cnt   <= w_half;
                    r_rx_state <= S_START;
                end
            end else if (r_rx_cnt != 16'd0) begin
                r_rx_cnt <= r_rx_cnt - 16'd1;
            end else begin
                r_rx_cnt <= r_div;
                unique case (r_rx_state)
                    S_START: begin
                        r_rx_bit   <= 3'd0;
                        r_rx_state <= w_rx ? S_IDLE : S_DATA;
                    end
                    S_DATA: begin
                        r_rx_sh  <= {w_rx, r_rx_sh[7:1]};
                        r_rx_bit <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7)
                            r_rx_state <= S_STOP;
                    end
                    S_STOP: begin
                        r_rx_state <= S_IDLE;
                        if (!w_rx) begin
                            r_rx_ferr <= 1'b1;
                        end else begin
                            r_rx_byte  <= r_rx_sh;
                            r_rx_valid <= 1'b1;
                            if (r_rx_valid && !w_rd_data)
                                r_rx_ovr <= 1'b1;
                        end
                    end
                    default: r_rx_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_int <= 3'd0;
        else if ((r_irqen[0] && r_rx_valid) || (r_irqen[1] && r_tx_ready))
            r_int <= IRQ_NUM;
        else
            r_int <= 3'd0;
    end

endmodule
